// File: rtl/rv32i_types.sv
// Shared RV32I type definitions: base opcodes and the fetch stage state encoding.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package rv32i_types;

  // Base RV32I major opcodes (instr[6:0]).
  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011
  } rv32i_opcode_t;

  // Instruction fetch sequencing states.
  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_READ,
    FETCH_FLUSH,
    FETCH_RESTART
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h4000_0060;

  // Instruction fetches are always word aligned; low address bits are dropped.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_register.sv
// 32-bit load-enable register with asynchronous active-low reset to RESET_VAL.
// Latency: d visible on q one cycle after en is sampled high.
// Backpressure: none; en alone decides whether q updates.
// Ports: clk, rst (async active-low), en (load enable), d (next value), q (held value).
module pc_register #(
  parameter logic [31:0] RESET_VAL = 32'h4000_0060
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] d,
  output logic [31:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, reads instruction memory, strobes each word into the IR.
// Latency: fetch_req at edge N -> mem_read after N; mem_resp at N+k -> ir_load for the cycle after N+k.
// Backpressure: mem_read/mem_address hold until mem_resp; fetch_req is only sampled in IDLE.
// Ports: clk, rst (async active-low); control fetch_req, pc_load, pc_target;
//        memory mem_address, mem_read, mem_rdata, mem_resp; IR ir_load, ir_data;
//        status pc, inst_pc, busy, misaligned.
module fetch_unit
  import rv32i_types::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_req,
  input  logic        pc_load,
  input  logic [31:0] pc_target,
  output logic [31:0] mem_address,
  output logic        mem_read,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp,
  output logic        ir_load,
  output logic [31:0] ir_data,
  output logic [31:0] pc,
  output logic [31:0] inst_pc,
  output logic        busy,
  output logic        misaligned
);

  fetch_state_t state;

  logic [31:0] target_aligned;
  logic [31:0] fetch_addr;
  logic [31:0] pc_d;
  logic        deliver;
  logic        pc_en;

  assign target_aligned = align_word(pc_target);

  // A response is handed to the IR only in READ and only if no redirect lands
  // in the same cycle; the redirect always wins.
  assign deliver = (state == FETCH_READ) && mem_resp && !pc_load;

  assign pc_en = pc_load || deliver;
  assign pc_d  = pc_load ? target_aligned : pc + 32'd4;

  // Address for a read launched this cycle: a simultaneous redirect is folded
  // in so the read and the PC never disagree.
  assign fetch_addr = pc_load ? target_aligned : pc;

  pc_register #(.RESET_VAL(RESET_PC)) u_pc (
    .clk (clk),
    .rst (rst),
    .en  (pc_en),
    .d   (pc_d),
    .q   (pc)
  );

  // In READ the PC still equals the address being read, so it names the
  // instruction being delivered.
  pc_register #(.RESET_VAL(RESET_PC)) u_inst_pc (
    .clk (clk),
    .rst (rst),
    .en  (deliver),
    .d   (pc),
    .q   (inst_pc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= FETCH_IDLE;
      mem_read    <= 1'b0;
      mem_address <= RESET_PC;
      ir_load     <= 1'b0;
      ir_data     <= 32'd0;
      busy        <= 1'b0;
      misaligned  <= 1'b0;
    end else begin
      ir_load    <= 1'b0;
      misaligned <= pc_load && (pc_target[1:0] != 2'b00);
      case (state)
        FETCH_IDLE: begin
          if (fetch_req) begin
            state       <= FETCH_READ;
            mem_read    <= 1'b1;
            mem_address <= fetch_addr;
            busy        <= 1'b1;
          end
        end
        FETCH_READ: begin
          if (mem_resp) begin
            mem_read <= 1'b0;
            if (pc_load) begin
              state <= FETCH_RESTART;
            end else begin
              ir_data <= mem_rdata;
              ir_load <= 1'b1;
              state   <= FETCH_IDLE;
              busy    <= 1'b0;
            end
          end else if (pc_load) begin
            // The old read cannot be cancelled; wait it out in FLUSH.
            state <= FETCH_FLUSH;
          end
        end
        FETCH_FLUSH: begin
          if (mem_resp) begin
            mem_read <= 1'b0;
            state    <= FETCH_RESTART;
          end
        end
        FETCH_RESTART: begin
          // One idle bus cycle separates the discarded read from the refetch.
          state       <= FETCH_READ;
          mem_read    <= 1'b1;
          mem_address <= fetch_addr;
        end
        default: begin
          state    <= FETCH_IDLE;
          mem_read <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: transaction-level model compared every cycle,
// plus directed literal checks of the key fetch/redirect/reset scenarios.
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h4000_0060;

  logic        clk;
  logic        rst;
  logic        fetch_req;
  logic        pc_load;
  logic [31:0] pc_target;
  logic [31:0] mem_address;
  logic        mem_read;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic        ir_load;
  logic [31:0] ir_data;
  logic [31:0] pc;
  logic [31:0] inst_pc;
  logic        busy;
  logic        misaligned;

  int n_cmp = 0;
  int n_err = 0;
  int ir_pulses = 0;
  logic prev_ir_load = 1'b0;

  fetch_unit #(.RESET_PC(RPC)) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_req   (fetch_req),
    .pc_load     (pc_load),
    .pc_target   (pc_target),
    .mem_address (mem_address),
    .mem_read    (mem_read),
    .mem_rdata   (mem_rdata),
    .mem_resp    (mem_resp),
    .ir_load     (ir_load),
    .ir_data     (ir_data),
    .pc          (pc),
    .inst_pc     (inst_pc),
    .busy        (busy),
    .misaligned  (misaligned)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks the read in flight (m_rd), whether its data is doomed (m_discard)
  // and a pending one-cycle bus gap before the refetch (m_gap).
  logic [31:0] m_pc, m_inst_pc, m_addr, m_ir_data;
  logic        m_rd, m_discard, m_gap, m_ir_load, m_mis;

  always @(posedge clk or negedge rst) begin : model
    logic [31:0] tgt;
    if (!rst) begin
      m_pc = RPC; m_inst_pc = RPC; m_addr = RPC; m_ir_data = 32'd0;
      m_rd = 1'b0; m_discard = 1'b0; m_gap = 1'b0; m_ir_load = 1'b0; m_mis = 1'b0;
    end else begin
      tgt       = pc_target & 32'hFFFF_FFFC;
      m_ir_load = 1'b0;
      m_mis     = pc_load && (pc_target % 4 != 0);
      if (m_gap) begin
        if (pc_load) m_pc = tgt;
        m_gap = 1'b0; m_rd = 1'b1; m_addr = m_pc; m_discard = 1'b0;
      end else if (!m_rd) begin
        if (pc_load) m_pc = tgt;
        if (fetch_req) begin
          m_rd = 1'b1; m_addr = m_pc; m_discard = 1'b0;
        end
      end else if (mem_resp) begin
        m_rd = 1'b0;
        if (m_discard || pc_load) begin
          if (pc_load) m_pc = tgt;
          m_gap = 1'b1;
        end else begin
          m_ir_data = mem_rdata; m_ir_load = 1'b1;
          m_inst_pc = m_addr;    m_pc = m_addr + 32'd4;
        end
      end else if (pc_load) begin
        m_pc = tgt; m_discard = 1'b1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("mdl_pc", pc, m_pc);
    chk("mdl_inst_pc", inst_pc, m_inst_pc);
    chk("mdl_mem_read", {31'd0, mem_read}, {31'd0, m_rd});
    if (m_rd) chk("mdl_mem_address", mem_address, m_addr);
    chk("mdl_ir_load", {31'd0, ir_load}, {31'd0, m_ir_load});
    chk("mdl_ir_data", ir_data, m_ir_data);
    chk("mdl_busy", {31'd0, busy}, {31'd0, (m_rd | m_gap)});
    chk("mdl_misaligned", {31'd0, misaligned}, {31'd0, m_mis});
    if (prev_ir_load) chk("ir_load_back_to_back", {31'd0, ir_load}, 32'd0);
    prev_ir_load = ir_load;
    if (ir_load) ir_pulses++;
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Launch a read from IDLE; returns at the negedge where READ is visible.
  task automatic issue_fetch();
    fetch_req = 1'b1;
    step(1);
    fetch_req = 1'b0;
  endtask

  task automatic respond(input logic [31:0] data);
    mem_resp  = 1'b1;
    mem_rdata = data;
    step(1);
    mem_resp  = 1'b0;
    mem_rdata = 32'd0;
  endtask

  initial begin : stim
    int p0;
    rst = 1'b0; fetch_req = 1'b0; pc_load = 1'b0; pc_target = 32'd0;
    mem_rdata = 32'd0; mem_resp = 1'b0;
    step(2);
    chk("rst_pc", pc, RPC);
    chk("rst_inst_pc", inst_pc, RPC);
    chk("rst_mem_address", mem_address, RPC);
    chk("rst_ir_data", ir_data, 32'd0);
    chk("rst_flags", {28'd0, mem_read, ir_load, busy, misaligned}, 32'd0);
    #2 rst = 1'b1;
    step(1);

    // Basic fetch with two wait cycles.
    p0 = ir_pulses;
    issue_fetch();
    chk("f1_mem_read", {31'd0, mem_read}, 32'd1);
    chk("f1_mem_address", mem_address, 32'h4000_0060);
    step(2);
    chk("f1_hold_address", mem_address, 32'h4000_0060);
    respond(32'h0000_0513);
    chk("f1_ir_load", {31'd0, ir_load}, 32'd1);
    chk("f1_ir_data", ir_data, 32'h0000_0513);
    chk("f1_pc", pc, 32'h4000_0064);
    chk("f1_inst_pc", inst_pc, 32'h4000_0060);
    step(1);
    chk("f1_ir_pulses", ir_pulses - p0, 32'd1);

    // Redirect one cycle into READ -> FLUSH -> RESTART -> refetch.
    p0 = ir_pulses;
    issue_fetch();
    pc_load = 1'b1; pc_target = 32'h4000_0100;
    step(1);
    pc_load = 1'b0;
    chk("fl_mem_read", {31'd0, mem_read}, 32'd1);
    chk("fl_old_address", mem_address, 32'h4000_0064);
    chk("fl_pc", pc, 32'h4000_0100);
    step(1);
    respond(32'hDEAD_BEEF);
    chk("fl_restart_read_low", {31'd0, mem_read}, 32'd0);
    chk("fl_restart_busy", {31'd0, busy}, 32'd1);
    step(1);
    chk("fl_refetch_read", {31'd0, mem_read}, 32'd1);
    chk("fl_refetch_address", mem_address, 32'h4000_0100);
    chk("fl_no_stale_strobe", ir_pulses - p0, 32'd0);
    respond(32'h0010_0093);
    chk("fl_ir_data", ir_data, 32'h0010_0093);
    chk("fl_inst_pc", inst_pc, 32'h4000_0100);
    chk("fl_pc_after", pc, 32'h4000_0104);
    step(1);

    // Redirect coinciding with the response: data dropped, refetch from target.
    p0 = ir_pulses;
    issue_fetch();
    mem_resp = 1'b1; mem_rdata = 32'h1234_5678;
    pc_load = 1'b1; pc_target = 32'h4000_0200;
    step(1);
    mem_resp = 1'b0; pc_load = 1'b0;
    chk("sc_ir_load", {31'd0, ir_load}, 32'd0);
    chk("sc_read_low", {31'd0, mem_read}, 32'd0);
    chk("sc_pc", pc, 32'h4000_0200);
    step(1);
    chk("sc_refetch_address", mem_address, 32'h4000_0200);
    chk("sc_no_strobe", ir_pulses - p0, 32'd0);
    respond(32'h0000_0073);
    chk("sc_inst_pc", inst_pc, 32'h4000_0200);
    step(1);

    // Misaligned redirect in IDLE.
    pc_load = 1'b1; pc_target = 32'h4000_0102;
    step(1);
    pc_load = 1'b0;
    chk("ma_pc", pc, 32'h4000_0100);
    chk("ma_pulse", {31'd0, misaligned}, 32'd1);
    step(1);
    chk("ma_pulse_end", {31'd0, misaligned}, 32'd0);

    // PC wrap-around.
    pc_load = 1'b1; pc_target = 32'hFFFF_FFFC;
    step(1);
    pc_load = 1'b0;
    issue_fetch();
    chk("wr_address", mem_address, 32'hFFFF_FFFC);
    respond(32'h0000_0013);
    chk("wr_pc", pc, 32'h0000_0000);
    chk("wr_inst_pc", inst_pc, 32'hFFFF_FFFC);
    step(1);

    // Reset while a read is outstanding; late response must be ignored.
    p0 = ir_pulses;
    issue_fetch();
    step(1);
    #2 rst = 1'b0;
    #1;
    chk("rr_read_drop", {31'd0, mem_read}, 32'd0);
    chk("rr_pc", pc, RPC);
    step(1);
    #2 rst = 1'b1;
    respond(32'hCAFE_F00D);
    chk("rr_no_load", {31'd0, ir_load}, 32'd0);
    chk("rr_busy", {31'd0, busy}, 32'd0);
    chk("rr_ir_data", ir_data, 32'd0);
    chk("rr_address", mem_address, RPC);
    step(2);
    chk("rr_no_strobe", ir_pulses - p0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the multicycle RV32I core: owns the program counter, issues word reads to instruction memory over a read/response handshake, and hands each returned instruction word to the instruction register with a one-cycle load strobe. Sits directly upstream of the instruction register and is sequenced by the control FSM (`fetch_req`, `pc_load`). Handles control-flow redirects that arrive while a read is outstanding by draining the stale response and refetching from the new target.

## Interface
- `RESET_PC`, 32'h4000_0060, PC value after reset.

- `clk`  in  1  core clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `fetch_req`  in  1  control requests the next instruction; sampled only in IDLE.
- `pc_load`  in  1  redirect: PC takes `pc_target`.
- `pc_target`  in  32  redirect address (branch/jump target).
- `mem_address`  out  32  instruction memory read address.
- `mem_read`  out  1  read request; held until `mem_resp`.
- `mem_rdata`  in  32  returned instruction word, valid with `mem_resp`.
- `mem_resp`  in  1  one-cycle read completion.
- `ir_load`  out  1  one-cycle strobe; instruction register captures `ir_data`.
- `ir_data`  out  32  instruction word being delivered.
- `pc`  out  32  address of the next fetch.
- `inst_pc`  out  32  address of the instruction last delivered.
- `busy`  out  1  high in any state other than IDLE.
- `misaligned`  out  1  one-cycle pulse: `pc_target[1:0]` was nonzero.

## Operation
- States: IDLE, READ, FLUSH, RESTART. All outputs registered.
- IDLE: `fetch_req` -> READ; `mem_address` <= `pc`, `mem_read` <= 1. `mem_resp` in IDLE is ignored.
- READ: `mem_read` and `mem_address` stay stable until `mem_resp`. On `mem_resp` without `pc_load`: `ir_data` <= `mem_rdata`, `ir_load` <= 1, `inst_pc` <= `pc`, `pc` <= `pc` + 4, `mem_read` <= 0, -> IDLE.
- `pc_load` in IDLE: `pc` <= target; state unchanged.
- `pc_load` in READ without `mem_resp`: `pc` <= target, -> FLUSH. The outstanding read is not cancelled.
- `pc_load` with `mem_resp` in the same READ cycle: the redirect wins. Data is discarded, `ir_load` stays 0, `pc` <= target, -> RESTART.
- FLUSH: `mem_read` and `mem_address` hold the old address. Further `pc_load` overwrites `pc` (latest wins). On `mem_resp`: discard, `mem_read` <= 0, -> RESTART.
- RESTART: `mem_read` is low for exactly one cycle, then -> READ with `mem_address` = current `pc`.
- Redirect alignment: `pc` <= {`pc_target`[31:2], 2'b00}. `misaligned` pulses on the next cycle when `pc_target[1:0]` ≠ 0.
- PC arithmetic: 32-bit modulo; 32'hFFFF_FFFC + 4 = 32'h0.
- `fetch_req` outside IDLE is ignored. Control holds it or re-asserts after `ir_load`.

## Timing
- Reset values: `pc` = RESET_PC, `inst_pc` = RESET_PC, `mem_address` = RESET_PC, `ir_data` = 0. `mem_read`, `ir_load`, `busy`, `misaligned` = 0. State = IDLE.
- Reset mid-read: takes effect immediately and asynchronously; `mem_read` drops. A late `mem_resp` after reset is ignored in IDLE.
- Latency from `fetch_req` sampled at edge N:
  - `mem_read` high after N.
  - `mem_resp` sampled at edge N+k (k ≥ 1) gives `ir_load` high for the cycle after N+k.
  - The instruction register holds the new instruction after edge N+k+1.
  - Minimum fetch is 3 cycles, request to IR valid.
- A redirect during READ costs the remaining stale-read latency + 1 RESTART cycle + a new read.
- `ir_load` is never high on two consecutive cycles.

## Structure
- `fetch_state_t` enum (IDLE, READ, FLUSH, RESTART) goes in `rv32i_types`, alongside the existing opcode types.
- One sub-module: `pc_register`, a 32-bit load-enable register with asynchronous active-low reset to RESET_PC. Used for `pc` and `inst_pc`.
- The FSM and datapath muxes live in `fetch_unit`.

## Test plan
- Reset, then `fetch_req` with `mem_resp` after 2 wait cycles, `mem_rdata` = 32'h0000_0513 -> `mem_address` = 32'h4000_0060, `ir_load` pulses once with `ir_data` = 32'h0000_0513, `pc` = 32'h4000_0064, `inst_pc` = 32'h4000_0060.
- `pc_load` with target 32'h4000_0100 one cycle into READ -> FLUSH, stale data never strobed, `mem_read` low 1 cycle, next read at 32'h4000_0100.
- `pc_load` in the same cycle as `mem_resp` -> no `ir_load`, RESTART, refetch from target.
- `pc_target` = 32'h4000_0102 in IDLE -> `pc` = 32'h4000_0100, `misaligned` pulses 1 cycle.
- `pc` = 32'hFFFF_FFFC, fetch completes -> `pc` = 32'h0000_0000.
- `rst` asserted while `mem_read` is high, `mem_resp` arrives afterwards -> all outputs at reset values, no `ir_load`.
